// File: rtl/conway_pkg.sv
// Shared constants for the conway board datapath.
package conway_pkg;

    localparam int BOARD_WIDTH = 64;

    // Bit-counter width for an n-bit word; a 1-bit word still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_to_parallel.sv
// Reassembles an LSB-first serial stream into data_size-bit words held in a
// single-entry output slot with valid/ready handoff and a sticky drop flag.
module serial_to_parallel
    import conway_pkg::*;
#(
    parameter int data_size = BOARD_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 DATA,
    input  logic                 SHIFT_EN,
    input  logic                 CLEAR,
    input  logic                 READY,
    output logic [data_size-1:0] DATA_OUT,
    output logic                 VALID,
    output logic                 BUSY,
    output logic                 OVERFLOW
);

    localparam int              CW   = cnt_width(data_size);
    localparam logic [CW-1:0]   LAST = CW'(data_size - 1);

    logic [data_size-1:0] sr;
    logic [data_size-1:0] word_next;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_next;
    logic                 complete;
    logic                 slot_free;

    // Written as shift-then-insert so the same expression holds for data_size=1.
    always_comb begin
        word_next                = sr >> 1;
        word_next[data_size-1]   = DATA;
        complete                 = SHIFT_EN && (cnt == LAST);
        cnt_next                 = complete ? '0 : cnt + CW'(1);
        slot_free                = !VALID || READY;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sr       <= '0;
            cnt      <= '0;
            DATA_OUT <= '0;
            VALID    <= 1'b0;
            BUSY     <= 1'b0;
            OVERFLOW <= 1'b0;
        end else if (CLEAR) begin
            sr       <= '0;
            cnt      <= '0;
            VALID    <= 1'b0;
            BUSY     <= 1'b0;
            OVERFLOW <= 1'b0;
        end else begin
            if (SHIFT_EN) begin
                sr   <= word_next;
                cnt  <= cnt_next;
                BUSY <= (cnt_next != '0);
            end
            // A completing word refills the slot if it is free, else it is dropped.
            if (complete && slot_free) begin
                DATA_OUT <= word_next;
                VALID    <= 1'b1;
            end else if (complete) begin
                OVERFLOW <= 1'b1;
            end else if (VALID && READY) begin
                VALID    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_to_parallel.sv
// Self-checking bench: 8-, 64- and 1-bit instances against a bit-collecting model.
module tb_serial_to_parallel;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;

    logic       d8 = 1'b0, se8 = 1'b0, clr8 = 1'b0, rdy8 = 1'b0;
    logic       d64 = 1'b0, se64 = 1'b0, clr64 = 1'b0, rdy64 = 1'b1;

    logic [7:0]  dout8;
    logic [63:0] dout64;
    logic [0:0]  dout1;
    logic        valid8, busy8, ovf8;
    logic        valid64, busy64, ovf64;
    logic        valid1, busy1, ovf1;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    serial_to_parallel #(.data_size(8)) dut8 (
        .CLK(CLK), .RST_N(RST_N), .DATA(d8), .SHIFT_EN(se8), .CLEAR(clr8), .READY(rdy8),
        .DATA_OUT(dout8), .VALID(valid8), .BUSY(busy8), .OVERFLOW(ovf8)
    );

    serial_to_parallel #(.data_size(64)) dut64 (
        .CLK(CLK), .RST_N(RST_N), .DATA(d64), .SHIFT_EN(se64), .CLEAR(clr64), .READY(rdy64),
        .DATA_OUT(dout64), .VALID(valid64), .BUSY(busy64), .OVERFLOW(ovf64)
    );

    // 1-bit instance shares the 8-bit stimulus: every shifted bit is a word.
    serial_to_parallel #(.data_size(1)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .DATA(d8), .SHIFT_EN(se8), .CLEAR(clr8), .READY(rdy8),
        .DATA_OUT(dout1), .VALID(valid1), .BUSY(busy1), .OVERFLOW(ovf1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          w_of[3] = '{8, 64, 1};
    logic        in_d[3], in_se[3], in_clr[3], in_rdy[3];
    logic [63:0] m_acc[3], m_dout[3];
    int          m_cnt[3];
    logic        m_valid[3], m_ovf[3];
    logic [63:0] a_dout[3];
    logic        a_valid[3], a_busy[3], a_ovf[3];

    always_comb begin
        in_d   = '{d8, d64, d8};
        in_se  = '{se8, se64, se8};
        in_clr = '{clr8, clr64, clr8};
        in_rdy = '{rdy8, rdy64, rdy8};
        a_dout  = '{64'(dout8), dout64, 64'(dout1)};
        a_valid = '{valid8, valid64, valid1};
        a_busy  = '{busy8, busy64, busy1};
        a_ovf   = '{ovf8, ovf64, ovf1};
    end

    always @(posedge CLK or negedge RST_N) begin
        bit refill;
        for (int i = 0; i < 3; i++) begin
            refill = 1'b0;
            if (!RST_N) begin
                m_acc[i] = '0; m_dout[i] = '0; m_cnt[i] = 0; m_valid[i] = 1'b0; m_ovf[i] = 1'b0;
            end else if (in_clr[i]) begin
                m_acc[i] = '0; m_cnt[i] = 0; m_valid[i] = 1'b0; m_ovf[i] = 1'b0;
            end else begin
                if (in_se[i]) begin
                    m_acc[i][m_cnt[i]] = in_d[i];
                    m_cnt[i]++;
                    if (m_cnt[i] == w_of[i]) begin
                        if (!m_valid[i] || in_rdy[i]) begin
                            m_dout[i] = m_acc[i];
                            refill = 1'b1;
                        end else begin
                            m_ovf[i] = 1'b1;
                        end
                        m_acc[i] = '0;
                        m_cnt[i] = 0;
                    end
                end
                if (refill) m_valid[i] = 1'b1;
                else if (m_valid[i] && in_rdy[i]) m_valid[i] = 1'b0;
            end
        end
    end

    always @(negedge CLK) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("dout[w=%0d]", w_of[i]), a_dout[i], m_dout[i]);
            chk($sformatf("valid[w=%0d]", w_of[i]), 64'(a_valid[i]), 64'(m_valid[i]));
            chk($sformatf("busy[w=%0d]", w_of[i]), 64'(a_busy[i]), 64'(m_cnt[i] != 0));
            chk($sformatf("overflow[w=%0d]", w_of[i]), 64'(a_ovf[i]), 64'(m_ovf[i]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic send8(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            d8 = w[i]; se8 = 1'b1;
        end
    endtask

    task automatic send64(input logic [63:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge CLK);
                se64 = 1'b0; d64 = ~d64;
            end
            @(negedge CLK);
            d64 = w[i]; se64 = 1'b1;
        end
    endtask

    task automatic chk_reset_zero();
        chk("rst dout64", dout64, 64'h0);
        chk("rst flags64", {61'h0, valid64, busy64, ovf64}, 64'h0);
        chk("rst dout8", 64'(dout8), 64'h0);
        chk("rst flags8", {61'h0, valid8, busy8, ovf8}, 64'h0);
    endtask

    localparam logic [63:0] WORD64 = 64'h0123456789ABCDEF;

    initial begin
        repeat (2) @(negedge CLK);
        chk_reset_zero();
        #2 RST_N = 1'b1;

        // Word 0x4D from bits 1,0,1,1,0,0,1,0; valid for exactly one cycle.
        rdy8 = 1'b1;
        send8(8'h4D);
        @(negedge CLK);
        se8 = 1'b0;
        chk("t1 dout", 64'(dout8), 64'h4D);
        chk("t1 valid", 64'(valid8), 64'h1);
        @(negedge CLK);
        chk("t1 valid drop", 64'(valid8), 64'h0);
        chk("t1 dout hold", 64'(dout8), 64'h4D);

        // Overflow: second word dropped while first is unconsumed.
        rdy8 = 1'b0;
        send8(8'hA5);
        send8(8'h3C);
        @(negedge CLK);
        se8 = 1'b0;
        chk("t2 dout", 64'(dout8), 64'hA5);
        chk("t2 valid", 64'(valid8), 64'h1);
        chk("t2 overflow", 64'(ovf8), 64'h1);
        rdy8 = 1'b1;
        @(negedge CLK);
        rdy8 = 1'b0;
        chk("t2 valid consumed", 64'(valid8), 64'h0);
        chk("t2 overflow sticky", 64'(ovf8), 64'h1);

        @(negedge CLK);
        clr8 = 1'b1;
        @(negedge CLK);
        clr8 = 1'b0;
        chk("clear overflow", 64'(ovf8), 64'h0);
        chk("clear keeps dout", 64'(dout8), 64'hA5);

        // Simultaneous consume and refill.
        send8(8'hFF);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (i == 0) begin
                chk("t3 first dout", 64'(dout8), 64'hFF);
                chk("t3 first valid", 64'(valid8), 64'h1);
            end
            d8 = (i == 0); se8 = 1'b1; rdy8 = (i == 7);
        end
        @(negedge CLK);
        se8 = 1'b0; rdy8 = 1'b0;
        chk("t3 refill dout", 64'(dout8), 64'h01);
        chk("t3 valid held", 64'(valid8), 64'h1);
        chk("t3 no overflow", 64'(ovf8), 64'h0);

        // CLEAR discards a partial word and wins over SHIFT_EN.
        rdy8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            d8 = 1'b1; se8 = 1'b1;
        end
        @(negedge CLK);
        se8 = 1'b0;
        chk("t4 busy", 64'(busy8), 64'h1);
        clr8 = 1'b1; se8 = 1'b1; d8 = 1'b1;
        @(negedge CLK);
        clr8 = 1'b0; se8 = 1'b0;
        chk("t4 busy cleared", 64'(busy8), 64'h0);
        send8(8'h81);
        @(negedge CLK);
        se8 = 1'b0;
        chk("t4 dout", 64'(dout8), 64'h81);
        chk("t4 valid", 64'(valid8), 64'h1);

        // 64-bit word with gaps, reset mid-word, then the full word again.
        send64(WORD64, 20);
        @(negedge CLK);
        se64 = 1'b0;
        chk("t5 busy mid", 64'(busy64), 64'h1);
        #3 RST_N = 1'b0;
        #1 chk_reset_zero();
        @(negedge CLK);
        chk_reset_zero();
        #2 RST_N = 1'b1;
        send64(WORD64, 64);
        @(negedge CLK);
        se64 = 1'b0;
        chk("t5 dout", dout64, WORD64);
        chk("t5 valid", 64'(valid64), 64'h1);
        chk("t5 overflow", 64'(ovf64), 64'h0);
        repeat (2) @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
